// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared types and constants for the decode/execute hazard controller.
package hazard_scoreboard_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_STALL = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_t;

    localparam int REG_X0            = 0;
    localparam int FLUSH_CYCLES_DEF  = 2;
    localparam int STALL_TIMEOUT_DEF = 63;

    // Counter widths cover the legal ranges 1..7 and 1..255.
    localparam int FLUSH_CNT_W = 3;
    localparam int STALL_CNT_W = 8;

endpackage

// File: rtl/hazard_scoreboard_ctrl_reg_scoreboard.sv
// Per-register busy flags with clear/set priority and source readiness lookups
// that honour the same-cycle writeback bypass.
module reg_scoreboard
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 squash_valid,
    input  logic [REG_IDX_W-1:0] squash_rd,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    output logic                 rs1_ready,
    output logic                 rs2_ready,
    output logic                 rd_busy,
    output logic [NUM_REGS-1:0]  busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;

    // Clears are applied before the set so a new producer wins over a retiring one.
    always_comb begin
        busy_nxt = busy_q;
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (squash_valid) begin
            busy_nxt[squash_rd] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_rd] = 1'b1;
        end
        busy_nxt[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign rs1_ready = ~busy_q[rs1] | (wb_valid & (wb_rd == rs1));
    assign rs2_ready = ~busy_q[rs2] | (wb_valid & (wb_rd == rs2));
    assign rd_busy   = busy_q[rd];
    assign busy      = busy_q;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage hazard controller: issue/stall/flush decisions, redirect flush
// sequencing and a sticky stall watchdog around a register busy scoreboard.
module hazard_scoreboard_ctrl
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int REG_IDX_W     = 5,
    parameter int FLUSH_CYCLES  = FLUSH_CYCLES_DEF,
    parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dec_valid_i,
    input  logic [REG_IDX_W-1:0] dec_rs1_i,
    input  logic [REG_IDX_W-1:0] dec_rs2_i,
    input  logic                 dec_use_rs1_i,
    input  logic                 dec_use_rs2_i,
    input  logic [REG_IDX_W-1:0] dec_rd_i,
    input  logic                 dec_wr_en_i,
    input  logic                 wb_valid_i,
    input  logic [REG_IDX_W-1:0] wb_rd_i,
    input  logic                 redirect_i,
    input  logic                 squash_valid_i,
    input  logic [REG_IDX_W-1:0] squash_rd_i,
    output logic                 issue_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic [NUM_REGS-1:0]  busy_o,
    output logic                 timeout_o
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_LIMIT  = STALL_CNT_W'(STALL_TIMEOUT);

    ctrl_state_t            state_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_nxt;
    logic                   timeout_q;

    logic rs1_ready;
    logic rs2_ready;
    logic rd_busy;
    logic hazard;
    logic blocked;
    logic set_en;

    reg_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb_valid     (wb_valid_i),
        .wb_rd        (wb_rd_i),
        .squash_valid (squash_valid_i),
        .squash_rd    (squash_rd_i),
        .set_en       (set_en),
        .set_rd       (dec_rd_i),
        .rs1          (dec_rs1_i),
        .rs2          (dec_rs2_i),
        .rd           (dec_rd_i),
        .rs1_ready    (rs1_ready),
        .rs2_ready    (rs2_ready),
        .rd_busy      (rd_busy),
        .busy         (busy_o)
    );

    // WAW has no writeback bypass: the older write must fully retire first.
    assign hazard  = dec_valid_i & ((dec_use_rs1_i & ~rs1_ready) |
                                    (dec_use_rs2_i & ~rs2_ready) |
                                    (dec_wr_en_i & rd_busy));
    assign blocked = redirect_i | (state_q == CTRL_FLUSH);

    assign issue_o = reset_n & dec_valid_i & ~hazard & ~blocked;
    assign stall_o = reset_n & hazard & ~blocked;
    assign flush_o = reset_n & blocked;
    assign set_en  = issue_o & dec_wr_en_i & (dec_rd_i != '0);

    // A stall seen from RUN starts the run at 1; further stall cycles saturate upward.
    assign stall_cnt_nxt = (state_q != CTRL_STALL) ? STALL_CNT_W'(1) :
                           (stall_cnt_q == '1)     ? stall_cnt_q :
                                                     stall_cnt_q + STALL_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CTRL_RUN;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_o ? stall_cnt_nxt : '0;
            timeout_q   <= timeout_q | (stall_o & (stall_cnt_nxt == STALL_LIMIT));
            if (redirect_i) begin
                state_q     <= CTRL_FLUSH;
                flush_cnt_q <= FLUSH_RELOAD;
            end else begin
                case (state_q)
                    CTRL_RUN: begin
                        if (stall_o) begin
                            state_q <= CTRL_STALL;
                        end
                    end
                    CTRL_STALL: begin
                        if (!hazard) begin
                            state_q <= CTRL_RUN;
                        end
                    end
                    CTRL_FLUSH: begin
                        if (flush_cnt_q == '0) begin
                            state_q <= CTRL_RUN;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - FLUSH_CNT_W'(1);
                        end
                    end
                    default: state_q <= CTRL_RUN;
                endcase
            end
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// behavioural model of the hazard controller.
module tb_hazard_scoreboard_ctrl;

    localparam int NUM_REGS      = 32;
    localparam int REG_IDX_W     = 5;
    localparam int FLUSH_CYCLES  = 2;
    localparam int STALL_TIMEOUT = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 dec_valid_i = 1'b0;
    logic [REG_IDX_W-1:0] dec_rs1_i = '0;
    logic [REG_IDX_W-1:0] dec_rs2_i = '0;
    logic                 dec_use_rs1_i = 1'b0;
    logic                 dec_use_rs2_i = 1'b0;
    logic [REG_IDX_W-1:0] dec_rd_i = '0;
    logic                 dec_wr_en_i = 1'b0;
    logic                 wb_valid_i = 1'b0;
    logic [REG_IDX_W-1:0] wb_rd_i = '0;
    logic                 redirect_i = 1'b0;
    logic                 squash_valid_i = 1'b0;
    logic [REG_IDX_W-1:0] squash_rd_i = '0;
    logic                 issue_o;
    logic                 stall_o;
    logic                 flush_o;
    logic [NUM_REGS-1:0]  busy_o;
    logic                 timeout_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: busy set, remaining flush bubbles, consecutive stall run.
    bit   m_busy[NUM_REGS];
    int   m_flush_left = 0;
    int   m_stall_run  = 0;
    bit   m_timeout    = 1'b0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl #(
        .NUM_REGS      (NUM_REGS),
        .REG_IDX_W     (REG_IDX_W),
        .FLUSH_CYCLES  (FLUSH_CYCLES),
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dec_valid_i    (dec_valid_i),
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_use_rs1_i  (dec_use_rs1_i),
        .dec_use_rs2_i  (dec_use_rs2_i),
        .dec_rd_i       (dec_rd_i),
        .dec_wr_en_i    (dec_wr_en_i),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .redirect_i     (redirect_i),
        .squash_valid_i (squash_valid_i),
        .squash_rd_i    (squash_rd_i),
        .issue_o        (issue_o),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    function automatic bit m_src_ready(logic [REG_IDX_W-1:0] s);
        return (s == 0) || !m_busy[s] || (wb_valid_i && (wb_rd_i == s));
    endfunction

    function automatic bit m_hazard();
        if (!dec_valid_i) return 1'b0;
        return (dec_use_rs1_i && !m_src_ready(dec_rs1_i)) ||
               (dec_use_rs2_i && !m_src_ready(dec_rs2_i)) ||
               (dec_wr_en_i && (dec_rd_i != 0) && m_busy[dec_rd_i]);
    endfunction

    // Returns {issue, stall, flush} for the current inputs.
    function automatic logic [2:0] m_expect();
        bit blocked;
        if (!reset_n) return 3'b000;
        blocked = redirect_i || (m_flush_left > 0);
        return {dec_valid_i && !m_hazard() && !blocked, m_hazard() && !blocked, blocked};
    endfunction

    function automatic logic [NUM_REGS-1:0] m_busy_vec();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_step();
        logic [2:0] e;
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
            m_flush_left = 0;
            m_stall_run  = 0;
            m_timeout    = 1'b0;
            return;
        end
        e = m_expect();
        if (wb_valid_i) m_busy[wb_rd_i] = 1'b0;
        if (squash_valid_i) m_busy[squash_rd_i] = 1'b0;
        if (e[2] && dec_wr_en_i && (dec_rd_i != 0)) m_busy[dec_rd_i] = 1'b1;
        if (redirect_i) m_flush_left = FLUSH_CYCLES;
        else if (m_flush_left > 0) m_flush_left--;
        if (e[1]) begin
            if (m_stall_run < 255) m_stall_run++;
            if (m_stall_run == STALL_TIMEOUT) m_timeout = 1'b1;
        end else begin
            m_stall_run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        dec_valid_i = 1'b0; dec_rs1_i = '0; dec_rs2_i = '0;
        dec_use_rs1_i = 1'b0; dec_use_rs2_i = 1'b0;
        dec_rd_i = '0; dec_wr_en_i = 1'b0;
        wb_valid_i = 1'b0; wb_rd_i = '0;
        redirect_i = 1'b0; squash_valid_i = 1'b0; squash_rd_i = '0;
    endtask

    task automatic issue_writer(logic [REG_IDX_W-1:0] rd);
        idle_inputs();
        dec_valid_i = 1'b1; dec_rd_i = rd; dec_wr_en_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        issue_writer(5'd4);
        redirect_i = 1'b1;
        #1;
        n_checks++; if ({issue_o, stall_o, flush_o} !== 3'b000) $display("FAIL reset_outputs: got %b want 000", {issue_o, stall_o, flush_o}); else n_pass++;
        tick();
        tick();
        n_checks++; if (busy_o !== '0) $display("FAIL reset_busy: got %h want 0", busy_o); else n_pass++;
        n_checks++; if (timeout_o !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_o); else n_pass++;
        reset_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_raw_bypass();
        issue_writer(5'd5);
        #1;
        n_checks++; if (issue_o !== 1'b1) $display("FAIL raw_writer_issue: got %b want 1", issue_o); else n_pass++;
        tick();
        idle_inputs();
        dec_valid_i = 1'b1; dec_rs1_i = 5'd5; dec_use_rs1_i = 1'b1;
        #1;
        n_checks++; if ({issue_o, stall_o} !== 2'b01) $display("FAIL raw_stall: got %b want 01", {issue_o, stall_o}); else n_pass++;
        n_checks++; if (busy_o[5] !== 1'b1) $display("FAIL raw_busy5_set: got %b want 1", busy_o[5]); else n_pass++;
        tick();
        wb_valid_i = 1'b1; wb_rd_i = 5'd5;
        #1;
        n_checks++; if ({issue_o, stall_o} !== 2'b10) $display("FAIL raw_bypass_issue: got %b want 10", {issue_o, stall_o}); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy_o[5] !== 1'b0) $display("FAIL raw_busy5_clear: got %b want 0", busy_o[5]); else n_pass++;
        tick();
    endtask

    task automatic test_x0();
        issue_writer(5'd0);
        #1;
        n_checks++; if (issue_o !== 1'b1) $display("FAIL x0_writer_issue: got %b want 1", issue_o); else n_pass++;
        tick();
        idle_inputs();
        dec_valid_i = 1'b1; dec_use_rs1_i = 1'b1; dec_use_rs2_i = 1'b1;
        #1;
        n_checks++; if ({issue_o, stall_o} !== 2'b10) $display("FAIL x0_reader: got %b want 10", {issue_o, stall_o}); else n_pass++;
        n_checks++; if (busy_o !== '0) $display("FAIL x0_busy: got %h want 0", busy_o); else n_pass++;
        tick();
    endtask

    task automatic test_redirect();
        logic [5:0] redir_pat;
        logic [5:0] flush_pat;
        // Isolated redirect: flush for the redirect cycle plus FLUSH_CYCLES.
        redir_pat = 6'b000001;
        flush_pat = 6'b000111;
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            dec_valid_i = 1'b1;
            redirect_i = redir_pat[k];
            #1;
            n_checks++; if ({flush_o, issue_o} !== {flush_pat[k], ~flush_pat[k]}) $display("FAIL redirect_single_c%0d: got flush/issue %b want %b", k, {flush_o, issue_o}, {flush_pat[k], ~flush_pat[k]}); else n_pass++;
            tick();
        end
        // A second redirect in the second flush cycle restarts the bubble.
        redir_pat = 6'b000011;
        flush_pat = 6'b001111;
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            dec_valid_i = 1'b1;
            redirect_i = redir_pat[k];
            #1;
            n_checks++; if ({flush_o, issue_o} !== {flush_pat[k], ~flush_pat[k]}) $display("FAIL redirect_double_c%0d: got flush/issue %b want %b", k, {flush_o, issue_o}, {flush_pat[k], ~flush_pat[k]}); else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_squash();
        issue_writer(5'd7);
        tick();
        idle_inputs();
        redirect_i = 1'b1; squash_valid_i = 1'b1; squash_rd_i = 5'd7;
        #1;
        n_checks++; if (busy_o[7] !== 1'b1) $display("FAIL squash_busy7_before: got %b want 1", busy_o[7]); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy_o[7] !== 1'b0) $display("FAIL squash_busy7_after: got %b want 0", busy_o[7]); else n_pass++;
        for (int k = 0; k < FLUSH_CYCLES; k++) tick();
        dec_valid_i = 1'b1; dec_rs2_i = 5'd7; dec_use_rs2_i = 1'b1;
        #1;
        n_checks++; if ({issue_o, stall_o, flush_o} !== 3'b100) $display("FAIL squash_reader: got %b want 100", {issue_o, stall_o, flush_o}); else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_set_wins();
        issue_writer(5'd9);
        wb_valid_i = 1'b1; wb_rd_i = 5'd9;
        #1;
        n_checks++; if (issue_o !== 1'b1) $display("FAIL setwin_issue: got %b want 1", issue_o); else n_pass++;
        tick();
        #1;
        n_checks++; if (busy_o[9] !== 1'b1) $display("FAIL setwin_busy9: got %b want 1", busy_o[9]); else n_pass++;
        // WAW against a busy rd is not bypassed by a same-cycle writeback.
        #1;
        n_checks++; if ({issue_o, stall_o} !== 2'b01) $display("FAIL setwin_waw_stall: got %b want 01", {issue_o, stall_o}); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy_o[9] !== 1'b0) $display("FAIL setwin_busy9_cleared: got %b want 0", busy_o[9]); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        issue_writer(5'd3);
        tick();
        idle_inputs();
        dec_valid_i = 1'b1; dec_rs2_i = 5'd3; dec_use_rs2_i = 1'b1;
        for (int k = 1; k <= STALL_TIMEOUT + 1; k++) begin
            tick();
            #1;
            n_checks++; if (timeout_o !== (k >= STALL_TIMEOUT)) $display("FAIL timeout_after_%0d: got %b want %b", k, timeout_o, (k >= STALL_TIMEOUT)); else n_pass++;
            n_checks++; if (stall_o !== 1'b1) $display("FAIL timeout_stall_%0d: got %b want 1", k, stall_o); else n_pass++;
        end
        wb_valid_i = 1'b1; wb_rd_i = 5'd3;
        #1;
        n_checks++; if (issue_o !== 1'b1) $display("FAIL timeout_release_issue: got %b want 1", issue_o); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (timeout_o !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_o); else n_pass++;
        tick();
        reset_n = 1'b0;
        dec_valid_i = 1'b1; dec_use_rs1_i = 1'b1; dec_rs1_i = 5'd3;
        tick();
        #1;
        n_checks++; if ({timeout_o, issue_o, stall_o, flush_o} !== 4'b0000) $display("FAIL timeout_reset_outputs: got %b want 0000", {timeout_o, issue_o, stall_o, flush_o}); else n_pass++;
        n_checks++; if (busy_o !== '0) $display("FAIL timeout_reset_busy: got %h want 0", busy_o); else n_pass++;
        reset_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [2:0] got;
        logic [2:0] want;
        for (int c = 0; c < 400; c++) begin
            reset_n        = ($urandom_range(0, 63) != 0);
            dec_valid_i    = ($urandom_range(0, 3) != 0);
            dec_rs1_i      = 5'($urandom_range(0, 7));
            dec_rs2_i      = 5'($urandom_range(0, 7));
            dec_use_rs1_i  = ($urandom_range(0, 1) != 0);
            dec_use_rs2_i  = ($urandom_range(0, 1) != 0);
            dec_rd_i       = 5'($urandom_range(0, 7));
            dec_wr_en_i    = ($urandom_range(0, 2) != 0);
            wb_valid_i     = ($urandom_range(0, 2) == 0);
            wb_rd_i        = 5'($urandom_range(0, 7));
            redirect_i     = ($urandom_range(0, 15) == 0);
            squash_valid_i = redirect_i && ($urandom_range(0, 1) != 0);
            squash_rd_i    = 5'($urandom_range(0, 7));
            #1;
            exp_q.push_back(m_expect());
            got  = {issue_o, stall_o, flush_o};
            want = exp_q.pop_front();
            n_checks++; if (got !== want) $display("FAIL rand_ctrl_c%0d: got issue/stall/flush %b want %b", c, got, want); else n_pass++;
            n_checks++; if (busy_o !== m_busy_vec()) $display("FAIL rand_busy_c%0d: got %h want %h", c, busy_o, m_busy_vec()); else n_pass++;
            n_checks++; if (timeout_o !== m_timeout) $display("FAIL rand_timeout_c%0d: got %b want %b", c, timeout_o, m_timeout); else n_pass++;
            tick();
        end
        reset_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_raw_bypass();
        test_x0();
        test_redirect();
        test_squash();
        test_set_wins();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
